// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX serializer among NUM_REQ byte sources,
// with packet locking and a stall timeout that forcibly releases a silent owner.
//
// state     | meaning
// IDLE      | no owner; round-robin picks the next requester once UART_TX is free
// ISSUE     | one-cycle o_TX_DV pulse for the latched byte
// WAIT_DONE | frame in flight; nothing accepted until i_TX_Done
// LOCKED    | owner keeps the transmitter between bytes of a packet; stall timer runs
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int LOCK_TIMEOUT = 1000
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic [NUM_REQ-1:0]     i_Req_Valid,
   input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
   input  logic [NUM_REQ-1:0]     i_Req_Last,
   output logic [NUM_REQ-1:0]     o_Req_Ready,
   output logic [NUM_REQ-1:0]     o_Grant,
   output logic                   o_TX_DV,
   output logic [7:0]             o_TX_Byte,
   input  logic                   i_TX_Active,
   input  logic                   i_TX_Done,
   output logic                   o_Busy,
   output logic                   o_Timeout
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, LOCKED} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   own_q, own_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               last_q, last_d;
   logic [7:0]         byte_q, byte_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_q, timeout_d;

   logic               rr_found;
   logic [IDX_W-1:0]   rr_idx;
   logic [IDX_W-1:0]   cand_idx;
   logic [IDX_W-1:0]   xfer_idx;
   logic               xfer;
   logic [7:0]         sel_byte;
   logic               sel_last;
   logic [NUM_REQ-1:0] sel_onehot;
   logic [NUM_REQ-1:0] ready;

   // Scan offsets from far to near so the requester closest after ptr wins.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand_idx = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand_idx = IDX_W'((int'(ptr_q) + off) % NUM_REQ);
         if (i_Req_Valid[cand_idx]) begin
            rr_found = 1'b1;
            rr_idx   = cand_idx;
         end
      end
   end

   assign xfer_idx = (state_q == IDLE) ? rr_idx : own_q;
   assign xfer     = |(ready & i_Req_Valid);

   always_comb begin
      sel_byte   = '0;
      sel_last   = 1'b0;
      sel_onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (xfer_idx == IDX_W'(k)) begin
            sel_byte      = i_Req_Byte[8*k +: 8];
            sel_last      = i_Req_Last[k];
            sel_onehot[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q   <= IDLE;
         ptr_q     <= IDX_W'(NUM_REQ - 1);
         own_q     <= '0;
         grant_q   <= '0;
         last_q    <= 1'b0;
         byte_q    <= 8'h00;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         own_q     <= own_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         byte_q    <= byte_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      own_d     = own_q;
      grant_d   = grant_q;
      last_d    = last_q;
      byte_d    = byte_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               byte_d  = sel_byte;
               last_d  = sel_last;
               own_d   = xfer_idx;
               grant_d = sel_onehot;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (i_TX_Done) begin
               if (last_q) begin
                  ptr_d   = own_q;
                  grant_d = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d   = '0;
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            // An owner byte on the terminal cycle wins over the timeout.
            if (xfer) begin
               byte_d  = sel_byte;
               last_d  = sel_last;
               state_d = ISSUE;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               ptr_d     = own_q;
               grant_d   = '0;
               cnt_d     = '0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = '0;
      case (state_q)
         IDLE:    if (!i_TX_Active && rr_found) ready[rr_idx] = 1'b1;
         LOCKED:  ready[own_q] = !i_TX_Active;
         default: ready = '0;
      endcase
      o_Req_Ready = ready;
      o_Grant     = grant_q;
      o_TX_DV     = (state_q == ISSUE);
      o_TX_Byte   = byte_q;
      o_Busy      = (state_q != IDLE);
      o_Timeout   = timeout_q;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester drivers, a UART_TX behavioural model
// and a scoreboard of expected TX bytes checked on every o_TX_DV pulse.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int NR    = 2;
   localparam int LT    = 5;
   localparam int FRAME = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [8*NR-1:0] req_byte  = '0;
   logic [NR-1:0]   req_last  = '0;
   logic [NR-1:0]   ready;
   logic [NR-1:0]   grant;
   logic            tx_dv;
   logic [7:0]      tx_byte;
   logic            tx_active = 1'b0;
   logic            tx_done   = 1'b0;
   logic            busy;
   logic            tmo;

   int total = 0;
   int bad   = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [7:0] exp_q[$];
   logic [NR-1:0] fire = '0;
   int fcnt = 0;

   uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(LT)) dut (
      .i_Clk       (clk),
      .i_Reset     (rst),
      .i_Req_Valid (req_valid),
      .i_Req_Byte  (req_byte),
      .i_Req_Last  (req_last),
      .o_Req_Ready (ready),
      .o_Grant     (grant),
      .o_TX_DV     (tx_dv),
      .o_TX_Byte   (tx_byte),
      .i_TX_Active (tx_active),
      .i_TX_Done   (tx_done),
      .o_Busy      (busy),
      .o_Timeout   (tmo)
   );

   always #5 clk = ~clk;

   // UART_TX stand-in; deliberately unaffected by rst.
   always @(posedge clk) begin
      tx_done <= 1'b0;
      if (tx_dv) begin
         tx_active <= 1'b1;
         fcnt      <= FRAME;
      end else if (tx_active) begin
         if (fcnt == 1) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
         end
         fcnt <= fcnt - 1;
      end
   end

   // Requester drivers: hold head of queue until accepted.
   initial begin
      logic [8:0] h;
      forever begin
         @(negedge clk);
         if (fire[0] && q0.size() > 0) void'(q0.pop_front());
         if (fire[1] && q1.size() > 0) void'(q1.pop_front());
         if (q0.size() > 0) begin
            h = q0[0];
            req_valid[0] = 1'b1; req_last[0] = h[8]; req_byte[7:0] = h[7:0];
         end else req_valid[0] = 1'b0;
         if (q1.size() > 0) begin
            h = q1[0];
            req_valid[1] = 1'b1; req_last[1] = h[8]; req_byte[15:8] = h[7:0];
         end else req_valid[1] = 1'b0;
         #1;
         fire = req_valid & ready & {NR{~rst}};
      end
   end

   // Scoreboard monitor.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         total++;
         if ($countones(ready) > 1) begin
            bad++; $display("FAIL ready_onehot: ready=%b required at most one bit set", ready);
         end
         if (tx_dv) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL dv_unexpected: byte=%h required no dv", tx_byte);
            end else begin
               e = exp_q.pop_front();
               if (tx_byte !== e) begin
                  bad++; $display("FAIL tx_byte: got %h required %h", tx_byte, e);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || busy || tx_active || fire != '0)
             && n < 400) begin
         @(negedge clk); #2; n++;
      end
      total++;
      if (n >= 400) begin
         bad++; $display("FAIL %s_drain: pending bytes=%0d required 0", name, exp_q.size());
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!tx_done && n < 200);
      total++;
      if (!tx_done) begin
         bad++; $display("FAIL %s_done_wait: tx_done=%b required 1 within 200 cycles", name, tx_done);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #2;
      total += 6;
      if (grant !== 2'b00)   begin bad++; $display("FAIL reset_grant: got %b required 00", grant); end
      if (ready !== 2'b00)   begin bad++; $display("FAIL reset_ready: got %b required 00", ready); end
      if (tx_dv !== 1'b0)    begin bad++; $display("FAIL reset_dv: got %b required 0", tx_dv); end
      if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
      if (tmo !== 1'b0)      begin bad++; $display("FAIL reset_timeout: got %b required 0", tmo); end
      if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h required 00", tx_byte); end
   endtask

   task automatic test_single();
      int n = 0;
      q0.push_back({1'b1, 8'h41}); exp_q.push_back(8'h41);
      do begin @(negedge clk); n++; end while (!tx_dv && n < 50);
      total += 2;
      if (grant !== 2'b01) begin bad++; $display("FAIL single_grant_dv: got %b required 01", grant); end
      if (busy !== 1'b1)   begin bad++; $display("FAIL single_busy_dv: got %b required 1", busy); end
      wait_done("single");
      total++;
      if (grant !== 2'b01) begin bad++; $display("FAIL single_grant_done: got %b required 01", grant); end
      @(negedge clk); #2;
      total += 2;
      if (grant !== 2'b00) begin bad++; $display("FAIL single_grant_release: got %b required 00", grant); end
      if (busy !== 1'b0)   begin bad++; $display("FAIL single_busy_release: got %b required 0", busy); end
      wait_idle("single");
   endtask

   task automatic test_contention();
      do_reset();
      q0.push_back({1'b1, 8'h10}); q0.push_back({1'b1, 8'h10});
      q1.push_back({1'b1, 8'h20});
      exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h10);
      wait_idle("contention");
   endtask

   task automatic test_packet_lock();
      int n = 0;
      do_reset();
      q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b1, 8'hA2});
      q1.push_back({1'b1, 8'hB0});
      exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hB0);
      wait_done("lock");
      @(negedge clk); #2;
      total++;
      if (tx_dv !== 1'b0) begin bad++; $display("FAIL lock_gap_d1: dv=%b required 0", tx_dv); end
      @(negedge clk); #2;
      total++;
      if (tx_dv !== 1'b1) begin bad++; $display("FAIL lock_gap_d2: dv=%b required 1", tx_dv); end
      while (grant == 2'b01 && n < 300) begin
         total++;
         if (ready[1] !== 1'b0) begin bad++; $display("FAIL lock_ready1: got %b required 0", ready[1]); end
         @(negedge clk); #2; n++;
      end
      total++;
      if (n >= 300) begin bad++; $display("FAIL lock_release: grant=%b required release", grant); end
      wait_idle("lock");
   endtask

   task automatic test_timeout();
      do_reset();
      q0.push_back({1'b0, 8'h55}); q1.push_back({1'b1, 8'h66});
      exp_q.push_back(8'h55); exp_q.push_back(8'h66);
      wait_done("timeout");
      for (int i = 1; i <= LT; i++) begin
         @(negedge clk); #2;
         total += 2;
         if (tmo !== 1'b0)    begin bad++; $display("FAIL timeout_early: cycle %0d tmo=%b required 0", i, tmo); end
         if (grant !== 2'b01) begin bad++; $display("FAIL timeout_hold: cycle %0d grant=%b required 01", i, grant); end
      end
      @(negedge clk); #2;
      total += 2;
      if (tmo !== 1'b1)    begin bad++; $display("FAIL timeout_pulse: tmo=%b required 1", tmo); end
      if (grant !== 2'b00) begin bad++; $display("FAIL timeout_release: grant=%b required 00", grant); end
      @(negedge clk); #2;
      total += 2;
      if (tmo !== 1'b0)    begin bad++; $display("FAIL timeout_once: tmo=%b required 0", tmo); end
      if (grant !== 2'b10) begin bad++; $display("FAIL timeout_next: grant=%b required 10", grant); end
      wait_idle("timeout");
   endtask

   task automatic test_timeout_valid();
      do_reset();
      q0.push_back({1'b0, 8'h71});
      exp_q.push_back(8'h71); exp_q.push_back(8'h72);
      wait_done("tvalid");
      repeat (LT - 1) @(negedge clk);
      #2;
      q0.push_back({1'b1, 8'h72});
      @(negedge clk); #2;
      total++;
      if (ready[0] !== 1'b1) begin bad++; $display("FAIL tvalid_ready: got %b required 1", ready[0]); end
      @(negedge clk); #2;
      total += 3;
      if (tx_dv !== 1'b1)  begin bad++; $display("FAIL tvalid_dv: got %b required 1", tx_dv); end
      if (tmo !== 1'b0)    begin bad++; $display("FAIL tvalid_tmo: got %b required 0", tmo); end
      if (grant !== 2'b01) begin bad++; $display("FAIL tvalid_grant: got %b required 01", grant); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #2;
         total++;
         if (tmo !== 1'b0) begin bad++; $display("FAIL tvalid_tmo_late: got %b required 0", tmo); end
      end
      wait_idle("tvalid");
   endtask

   task automatic test_reset_midframe();
      int n = 0;
      do_reset();
      q0.push_back({1'b1, 8'h80}); exp_q.push_back(8'h80);
      do begin @(negedge clk); n++; end while (!tx_active && n < 50);
      q1.push_back({1'b1, 8'h88}); exp_q.push_back(8'h88);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2;
      total += 6;
      if (grant !== 2'b00)   begin bad++; $display("FAIL mid_grant: got %b required 00", grant); end
      if (ready !== 2'b00)   begin bad++; $display("FAIL mid_ready: got %b required 00", ready); end
      if (tx_dv !== 1'b0)    begin bad++; $display("FAIL mid_dv: got %b required 0", tx_dv); end
      if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy: got %b required 0", busy); end
      if (tmo !== 1'b0)      begin bad++; $display("FAIL mid_timeout: got %b required 0", tmo); end
      if (tx_byte !== 8'h00) begin bad++; $display("FAIL mid_byte: got %h required 00", tx_byte); end
      n = 0;
      while (tx_active && n < 50) begin
         @(negedge clk); #2; n++;
         total++;
         if (tx_active && grant !== 2'b00) begin
            bad++; $display("FAIL mid_early_grant: got %b required 00", grant);
         end
      end
      wait_idle("midframe");
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_packet_lock();
      test_timeout();
      test_timeout_valid();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
